// File: rtl/rr_sel_arbiter.sv
// Round-robin arbiter producing the binary select and one-hot grant for a downstream N-to-1 mux,
// held under a valid/ready handshake. Define RR_SEL_ARBITER_FIXED_PRIO_EN for fixed lowest-index priority.
module rr_sel_arbiter #(
    parameter int unsigned NUM_OF_INPUTS = 5,
    localparam int unsigned SEL_WIDTH    = $clog2(NUM_OF_INPUTS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_OF_INPUTS-1:0] req,
    input  logic                     ready,
    output logic                     valid,
    output logic [SEL_WIDTH-1:0]     sel,
    output logic [NUM_OF_INPUTS-1:0] gnt,
    output logic [NUM_OF_INPUTS-1:0] ack
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [SEL_WIDTH-1:0]     r_sel;
    logic [SEL_WIDTH-1:0]     w_sel_nxt;
    logic [SEL_WIDTH-1:0]     r_ptr;
    logic [SEL_WIDTH-1:0]     w_ptr_nxt;
    logic [NUM_OF_INPUTS-1:0] r_gnt;
    logic [NUM_OF_INPUTS-1:0] w_gnt_nxt;

    logic                     w_accept;
    logic [SEL_WIDTH-1:0]     w_ptr_inc;
    logic [NUM_OF_INPUTS-1:0] w_arb_req;
    logic [SEL_WIDTH-1:0]     w_arb_ptr;
    logic                     w_arb_found;
    logic [SEL_WIDTH-1:0]     w_arb_idx;
    logic [NUM_OF_INPUTS-1:0] w_arb_onehot;

    assign w_accept = (r_state == ST_GRANT) && ready;

    // Pointer after an accept; wraps at NUM_OF_INPUTS, not at 2**SEL_WIDTH.
`ifdef RR_SEL_ARBITER_FIXED_PRIO_EN
    assign w_ptr_inc = '0;
`else
    assign w_ptr_inc = (r_sel == SEL_WIDTH'(NUM_OF_INPUTS - 1)) ? '0 : r_sel + SEL_WIDTH'(1);
`endif

    // In GRANT the current holder is masked and the search starts just past it.
    assign w_arb_req = (r_state == ST_GRANT) ? (req & ~r_gnt) : req;
    assign w_arb_ptr = (r_state == ST_GRANT) ? w_ptr_inc : r_ptr;

    always_comb begin
        int unsigned v_pos;
        v_pos        = 0;
        w_arb_found  = 1'b0;
        w_arb_idx    = '0;
        w_arb_onehot = '0;
        for (int unsigned i = 0; i < NUM_OF_INPUTS; i++) begin
            v_pos = 32'(w_arb_ptr) + i;
            if (v_pos >= NUM_OF_INPUTS) begin
                v_pos = v_pos - NUM_OF_INPUTS;
            end
            if (!w_arb_found && w_arb_req[v_pos[SEL_WIDTH-1:0]]) begin
                w_arb_found = 1'b1;
                w_arb_idx   = v_pos[SEL_WIDTH-1:0];
            end
        end
        w_arb_onehot[w_arb_idx] = w_arb_found;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sel_nxt   = r_sel;
        w_gnt_nxt   = r_gnt;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (w_arb_found) begin
                    w_state_nxt = ST_GRANT;
                    w_sel_nxt   = w_arb_idx;
                    w_gnt_nxt   = w_arb_onehot;
                end
            end
            ST_GRANT: begin
                if (w_accept) begin
                    w_ptr_nxt = w_ptr_inc;
                    if (w_arb_found) begin
                        w_sel_nxt = w_arb_idx;
                        w_gnt_nxt = w_arb_onehot;
                    end else begin
                        w_state_nxt = ST_IDLE;
                        w_gnt_nxt   = '0;
                    end
                end else if (!req[r_sel]) begin
                    w_state_nxt = ST_IDLE;
                    w_gnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_gnt   <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sel   <= w_sel_nxt;
            r_gnt   <= w_gnt_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    assign valid = (r_state == ST_GRANT);
    assign sel   = r_sel;
    assign gnt   = r_gnt;
    assign ack   = r_gnt & {NUM_OF_INPUTS{valid & ready & rst_n}};

endmodule
